// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared state encoding, default width and counter sizing for the serial adder
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_cell.sv
// rtl/serial_add_cell.sv - one-bit Mealy full adder with its carry flip-flop
module serial_add_cell (
  input  logic clock,
  input  logic reset,
  input  logic x,
  input  logic y,
  input  logic enable,
  input  logic init,
  input  logic cin_init,
  output logic s,
  output logic carry_q
);

  assign s = x ^ y ^ carry_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
    end else if (init) begin
      carry_q <= cin_init;
    end else if (enable) begin
      carry_q <= (x & y) | (x & carry_q) | (y & carry_q);
    end
  end

endmodule

// File: rtl/serial_add_controller.sv
// rtl/serial_add_controller.sv - bit-serial add/subtract controller, LSB first, one bit per clock
module serial_add_controller
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] areg;
  logic [WIDTH-1:0] breg;
  logic [WIDTH-2:0] acc;
  logic [WIDTH-1:0] next_res;
  logic [CW-1:0]    count;
  logic             s;
  logic             carry_q;
  logic             carry_next;
  logic             load;
  logic             step;

  assign load = (state == IDLE) && start;
  assign step = (state == SHIFT) && !abort;

  serial_add_cell u_cell (
    .clock    (clock),
    .reset    (reset),
    .x        (areg[0]),
    .y        (breg[0]),
    .enable   (step),
    .init     (load),
    .cin_init (sub),
    .s        (s),
    .carry_q  (carry_q)
  );

  // The cell only exposes the registered carry; the final carry-out is needed on the same edge.
  assign carry_next = (areg[0] & breg[0]) | (areg[0] & carry_q) | (breg[0] & carry_q);
  assign next_res   = {s, acc};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
      areg     <= '0;
      breg     <= '0;
      acc      <= '0;
      count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            areg  <= a;
            breg  <= sub ? ~b : b;
            count <= '0;
            state <= SHIFT;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            areg <= areg >> 1;
            breg <= breg >> 1;
            acc  <= next_res[WIDTH-1:1];
            if (count == LAST) begin
              // carry_q here is the carry into the MSB.
              sum      <= next_res;
              cout     <= carry_next;
              overflow <= carry_q ^ carry_next;
              state    <= DONE;
              done     <= 1'b1;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_add_controller.md
SERIAL_ADD_CONTROLLER -- requirements
Module: serial_add_controller

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving operand/result width in bits (legal range 2..32).
REQ-002 SHALL have input clock, 1 bit: rising-edge clock.
REQ-003 SHALL have input reset, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input start, 1 bit: request to begin an operation.
REQ-005 SHALL have input sub, 1 bit: 0 = add (a+b), 1 = subtract (a-b); sampled with start.
REQ-006 SHALL have input a, WIDTH bits: first operand; sampled with start.
REQ-007 SHALL have input b, WIDTH bits: second operand; sampled with start.
REQ-008 SHALL have input abort, 1 bit: synchronous cancel of an operation in progress.
REQ-009 SHALL have output ready, 1 bit: high only in IDLE.
REQ-010 SHALL have output busy, 1 bit: high in SHIFT and DONE.
REQ-011 SHALL have output done, 1 bit: one-cycle pulse marking result valid.
REQ-012 SHALL have output sum, WIDTH bits: registered result.
REQ-013 SHALL have output cout, 1 bit: carry out (for subtract, 1 = no borrow).
REQ-014 SHALL have output overflow, 1 bit: two's-complement signed overflow.

Function
REQ-015 SHALL implement three states: IDLE, SHIFT, DONE.
REQ-016 IDLE: start=1 at a rising edge SHALL load A<=a, B<=(sub ? ~b : b), carry<=sub, bit counter<=0, and set state to SHIFT; start=0 SHALL stay in IDLE.
REQ-017 SHIFT: each edge SHALL process one bit, LSB first, as s=A[0]^B[0]^carry and carry<=majority(A[0],B[0],carry); SHALL shift A and B right and shift s into the MSB of the result shift register.
REQ-018 SHIFT: on the edge with counter=WIDTH-1 SHALL latch sum, cout = final carry, and overflow = (carry into MSB) XOR (final carry), then enter DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-020 Latency: for start sampled at edge E0, done SHALL be high between edges E0+WIDTH and E0+WIDTH+1, and ready SHALL be high again after edge E0+WIDTH+1.
REQ-021 start while busy=1 SHALL be ignored; no queuing.
REQ-022 abort=1 in SHIFT SHALL return the block to IDLE at the next edge, with no done pulse and sum/cout/overflow unchanged; abort SHALL be ignored in IDLE and DONE.
REQ-023 abort and start both high in IDLE SHALL start the operation (abort is ignored).
REQ-024 sum, cout and overflow SHALL hold their value from the last completed operation until the next completion.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; the counter SHALL be clog2(WIDTH) bits and SHALL NOT wrap inside an operation.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, overflow=0, carry=0, counter=0, independent of clock.
REQ-027 Reset during SHIFT or DONE SHALL discard the operation with no done pulse; after reset releases, the first edge SHALL be able to accept start.

Structure
REQ-028 Shared package serial_add_pkg SHALL hold the state encoding (IDLE, SHIFT, DONE), the default WIDTH, and the counter-width function.
REQ-029 The bit slice SHALL be sub-module serial_add_cell: a Mealy full-adder with a carry flip-flop, inputs x, y, enable, init, cin_init, clock, reset, and outputs s and carry_q; it uses the same asynchronous active-low reset.

Verification (WIDTH=8)
REQ-030 Add 8'h35+8'h4A -> done at E0+8, sum=8'h7F, cout=0, overflow=0.
REQ-031 Add 8'hFF+8'h01 -> sum=8'h00, cout=1, overflow=0; add 8'h7F+8'h01 -> sum=8'h80, cout=0, overflow=1.
REQ-032 Sub 8'h10-8'h20 -> sum=8'hF0, cout=0, overflow=0; sub 8'h80-8'h01 -> sum=8'h7F, cout=1, overflow=1.
REQ-033 start re-asserted with new operands at E0+3 -> ignored; result equals the first operation, exactly one done pulse.
REQ-034 abort at E0+4 -> IDLE at E0+5, no done, previous sum retained; next start completes normally.
REQ-035 reset pulsed low mid-SHIFT -> all outputs reach reset values without a clock edge; no done pulse afterwards.
